// File: rtl/data_memory_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU data port and the debug/loader port.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking instead of CPU priority with a starvation bound.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_CONSEC = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  CpuReq,
  input  logic                  CpuWr,
  input  logic [ADDR_WIDTH-1:0] CpuAddr,
  input  logic [DATA_WIDTH-1:0] CpuWrData,
  output logic [DATA_WIDTH-1:0] CpuRdData,
  output logic                  CpuAck,
  input  logic                  DbgReq,
  input  logic                  DbgWr,
  input  logic [ADDR_WIDTH-1:0] DbgAddr,
  input  logic [DATA_WIDTH-1:0] DbgWrData,
  output logic [DATA_WIDTH-1:0] DbgRdData,
  output logic                  DbgAck,
  output logic                  MemRd,
  output logic                  MemWr,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWrData,
  input  logic [DATA_WIDTH-1:0] MemRdData,
  output logic                  Busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    owner_dbg_r;
  logic                    txn_wr_r;
  logic                    grant_s;
  logic                    grant_dbg_s;
  logic                    sel_wr_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic                    mem_rd_r;
  logic                    mem_wr_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;
  logic                    cpu_ack_r;
  logic                    dbg_ack_r;
  logic [DATA_WIDTH-1:0]   cpu_rdata_r;
  logic [DATA_WIDTH-1:0]   dbg_rdata_r;
  logic                    busy_r;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dbg_r;

  // Arbitration: a tie goes to whichever port did not own the previous transaction.
  always_comb begin
    grant_s     = 1'b0;
    grant_dbg_s = 1'b0;
    if (CpuReq && DbgReq) begin
      grant_s     = 1'b1;
      grant_dbg_s = ~last_dbg_r;
    end else if (CpuReq) begin
      grant_s     = 1'b1;
      grant_dbg_s = 1'b0;
    end else if (DbgReq) begin
      grant_s     = 1'b1;
      grant_dbg_s = 1'b1;
    end else begin
      grant_s     = 1'b0;
      grant_dbg_s = 1'b0;
    end
  end

  // Last-owner register; starts at debug so the CPU wins the first tie.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_dbg_r <= 1'b1;
    end else if (state_r == ST_IDLE && grant_s) begin
      last_dbg_r <= grant_dbg_s;
    end
  end
`else
  localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

  logic [3:0] consec_r;
  logic [3:0] consec_s;

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
    if (val >= lim) begin
      return lim;
    end else begin
      return val + 4'd1;
    end
  endfunction

  // Arbitration: CPU first, unless debug has waited through MAX_CONSEC CPU grants.
  always_comb begin
    grant_s     = 1'b0;
    grant_dbg_s = 1'b0;
    if (CpuReq && !(DbgReq && consec_r == MAX_CNT)) begin
      grant_s     = 1'b1;
      grant_dbg_s = 1'b0;
    end else if (DbgReq) begin
      grant_s     = 1'b1;
      grant_dbg_s = 1'b1;
    end else begin
      grant_s     = 1'b0;
      grant_dbg_s = 1'b0;
    end
  end

  // Starvation counter: counts CPU grants taken while debug is waiting.
  always_comb begin
    consec_s = consec_r;
    if (state_r != ST_IDLE) begin
      consec_s = consec_r;
    end else if (!DbgReq || grant_dbg_s) begin
      consec_s = 4'd0;
    end else begin
      consec_s = sat_inc(consec_r, MAX_CNT);
    end
  end

  // Starvation counter register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      consec_r <= 4'd0;
    end else begin
      consec_r <= consec_s;
    end
  end
`endif

  // Winner's request fields, latched on the IDLE grant.
  always_comb begin
    sel_wr_s    = CpuWr;
    sel_addr_s  = CpuAddr;
    sel_wdata_s = CpuWrData;
    if (grant_dbg_s) begin
      sel_wr_s    = DbgWr;
      sel_addr_s  = DbgAddr;
      sel_wdata_s = DbgWrData;
    end else begin
      sel_wr_s    = CpuWr;
      sel_addr_s  = CpuAddr;
      sel_wdata_s = CpuWrData;
    end
  end

  // Next-state logic: every transaction walks IDLE->ISSUE->CAPTURE->DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE:   state_s = ST_CAPTURE;
      ST_CAPTURE: state_s = ST_DONE;
      ST_DONE:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Memory-side outputs are loaded on the grant edge so they appear exactly in ISSUE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mem_rd_r    <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      owner_dbg_r <= 1'b0;
      txn_wr_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r   <= (state_s != ST_IDLE);
      mem_rd_r <= 1'b0;
      mem_wr_r <= 1'b0;
      if (state_r == ST_IDLE && grant_s) begin
        owner_dbg_r <= grant_dbg_s;
        txn_wr_r    <= sel_wr_s;
        mem_addr_r  <= sel_addr_s;
        mem_wdata_r <= sel_wdata_s;
        mem_rd_r    <= ~sel_wr_s;
        mem_wr_r    <= sel_wr_s;
      end
    end
  end

  // Requester-side outputs: read data captured in CAPTURE, ack pulsed during DONE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cpu_ack_r   <= 1'b0;
      dbg_ack_r   <= 1'b0;
      cpu_rdata_r <= '0;
      dbg_rdata_r <= '0;
    end else begin
      cpu_ack_r <= 1'b0;
      dbg_ack_r <= 1'b0;
      if (state_r == ST_CAPTURE) begin
        cpu_ack_r <= ~owner_dbg_r;
        dbg_ack_r <= owner_dbg_r;
        if (!txn_wr_r) begin
          if (owner_dbg_r) begin
            dbg_rdata_r <= MemRdData;
          end else begin
            cpu_rdata_r <= MemRdData;
          end
        end
      end
    end
  end

  assign MemRd     = mem_rd_r;
  assign MemWr     = mem_wr_r;
  assign MemAddr   = mem_addr_r;
  assign MemWrData = mem_wdata_r;
  assign CpuAck    = cpu_ack_r;
  assign DbgAck    = dbg_ack_r;
  assign CpuRdData = cpu_rdata_r;
  assign DbgRdData = dbg_rdata_r;
  assign Busy      = busy_r;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed cases plus random two-port traffic
// compared each cycle against a transaction-level reference model and a memory image.
module tb_data_memory_arbiter;
  localparam int AW   = 11;
  localparam int DW   = 16;
  localparam int MAXC = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          CpuReq, CpuWr, DbgReq, DbgWr;
  logic [AW-1:0] CpuAddr, DbgAddr;
  logic [DW-1:0] CpuWrData, DbgWrData;
  logic [DW-1:0] CpuRdData, DbgRdData;
  logic          CpuAck, DbgAck, MemRd, MemWr, Busy;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemWrData;
  logic [DW-1:0] MemRdData;

  int total = 0;
  int bad   = 0;

  logic          mem_init;
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  // reference model state
  int            m_phase;
  bit            m_dbg, m_wr, m_last_dbg;
  int            m_cpu_streak;
  logic [DW-1:0] m_rdata;
  logic          e_mrd, e_mwr, e_cack, e_dack, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_crd, e_drd;

  bit order [6];
  bit exp_order [6];
  int n;

  always #5 Clock = ~Clock;

  data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_CONSEC(MAXC)) dut (
    .Clock(Clock), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWr(CpuWr), .CpuAddr(CpuAddr), .CpuWrData(CpuWrData),
    .CpuRdData(CpuRdData), .CpuAck(CpuAck),
    .DbgReq(DbgReq), .DbgWr(DbgWr), .DbgAddr(DbgAddr), .DbgWrData(DbgWrData),
    .DbgRdData(DbgRdData), .DbgAck(DbgAck),
    .MemRd(MemRd), .MemWr(MemWr), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemRdData(MemRdData), .Busy(Busy)
  );

  // single-port memory: registered read, write on strobe
  always @(posedge Clock) begin
    if (mem_init) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 16'h0000;
      mem[11'h7FF] <= 16'h1234;
    end else begin
      if (MemWr) mem[MemAddr] <= MemWrData;
      if (MemRd) MemRdData <= mem[MemAddr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cpu_streak = 0; m_last_dbg = 1'b1; m_dbg = 1'b0; m_wr = 1'b0;
    e_mrd = 1'b0; e_mwr = 1'b0; e_cack = 1'b0; e_dack = 1'b0; e_busy = 1'b0;
    e_addr = '0; e_wdata = '0; e_crd = '0; e_drd = '0; m_rdata = '0;
  endtask

  // One clock of the reference model, using the requests present at the edge.
  task automatic model_step();
    bit g, gd;
    g = 1'b0; gd = 1'b0;
    e_mrd = 1'b0; e_mwr = 1'b0; e_cack = 1'b0; e_dack = 1'b0;
    case (m_phase)
      0: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (CpuReq && DbgReq) begin g = 1'b1; gd = !m_last_dbg; end
        else if (CpuReq) g = 1'b1;
        else if (DbgReq) begin g = 1'b1; gd = 1'b1; end
`else
        if (CpuReq && !(DbgReq && m_cpu_streak >= MAXC)) g = 1'b1;
        else if (DbgReq) begin g = 1'b1; gd = 1'b1; end
        if (!DbgReq || gd) m_cpu_streak = 0;
        else if (m_cpu_streak < MAXC) m_cpu_streak++;
`endif
        if (g) begin
          m_dbg      = gd;
          m_last_dbg = gd;
          m_wr       = gd ? DbgWr : CpuWr;
          e_addr     = gd ? DbgAddr : CpuAddr;
          e_wdata    = gd ? DbgWrData : CpuWrData;
          e_mrd      = !m_wr;
          e_mwr      = m_wr;
          m_phase    = 1;
        end
      end
      1: begin
        if (m_wr) ref_mem[e_addr] = e_wdata;
        else m_rdata = ref_mem[e_addr];
        m_phase = 2;
      end
      2: begin
        if (!m_wr) begin
          if (m_dbg) e_drd = m_rdata;
          else e_crd = m_rdata;
        end
        if (m_dbg) e_dack = 1'b1;
        else e_cack = 1'b1;
        m_phase = 3;
      end
      default: m_phase = 0;
    endcase
    e_busy = (m_phase != 0);
  endtask

  task automatic check_all();
    check_val("memrd", MemRd, e_mrd);
    check_val("memwr", MemWr, e_mwr);
    check_val("memaddr", MemAddr, e_addr);
    check_val("memwdata", MemWrData, e_wdata);
    check_val("cpuack", CpuAck, e_cack);
    check_val("dbgack", DbgAck, e_dack);
    check_val("cpurddata", CpuRdData, e_crd);
    check_val("dbgrddata", DbgRdData, e_drd);
    check_val("busy", Busy, e_busy);
    check_val("strobe_excl", MemRd & MemWr, 1'b0);
    check_val("ack_excl", CpuAck & DbgAck, 1'b0);
  endtask

  task automatic step();
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    check_all();
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    #1;
    model_reset();
    @(negedge Clock);
    Reset = 1'b0;
    check_all();
  endtask

  task automatic rand_port(input logic acked, inout logic req, inout logic wr,
                           inout logic [AW-1:0] addr, inout logic [DW-1:0] data);
    if (acked || !req) begin
      if (acked) req = 1'($urandom_range(0, 1));
      else req = ($urandom_range(0, 3) == 0);
      if (req) begin
        wr   = 1'($urandom_range(0, 1));
        addr = AW'($urandom_range(0, 15));
        data = DW'($urandom);
      end
    end else if ($urandom_range(0, 9) == 0) begin
      addr = AW'($urandom_range(0, 15));
      data = DW'($urandom);
    end else if ($urandom_range(0, 31) == 0) begin
      req = 1'b0;
    end
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    Reset = 1'b1; mem_init = 1'b1;
    CpuReq = 1'b0; CpuWr = 1'b0; CpuAddr = '0; CpuWrData = '0;
    DbgReq = 1'b0; DbgWr = 1'b0; DbgAddr = '0; DbgWrData = '0;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 16'h0000;
    ref_mem[11'h7FF] = 16'h1234;
    model_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    mem_init = 1'b0;
    Reset = 1'b0;
    check_all();

    // CPU write 0xBEEF to 0x005
    CpuReq = 1'b1; CpuWr = 1'b1; CpuAddr = 11'h005; CpuWrData = 16'hBEEF;
    step();
    check_val("wr_issue_memwr", MemWr, 1'b1);
    check_val("wr_issue_addr", MemAddr, 11'h005);
    check_val("wr_issue_data", MemWrData, 16'hBEEF);
    step(); step();
    check_val("wr_cpuack", CpuAck, 1'b1);
    check_val("wr_dbgack", DbgAck, 1'b0);
    CpuReq = 1'b0;
    step();

    // CPU read back 0x005
    CpuReq = 1'b1; CpuWr = 1'b0;
    step();
    check_val("rd_issue_memrd", MemRd, 1'b1);
    step(); step();
    check_val("rd_cpuack", CpuAck, 1'b1);
    check_val("rd_cpurddata", CpuRdData, 16'hBEEF);
    check_val("rd_dbgrddata", DbgRdData, 16'h0000);
    CpuReq = 1'b0;
    step();

    // both ports held high: grant order
    reset_dut();
    CpuReq = 1'b1; CpuWr = 1'b0; CpuAddr = 11'h003;
    DbgReq = 1'b1; DbgWr = 1'b0; DbgAddr = 11'h004;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      step();
      if (CpuAck) begin order[n] = 1'b0; n++; end
      else if (DbgAck) begin order[n] = 1'b1; n++; end
    end
    check_val("order_count", n, 6);
    for (int i = 0; i < 6; i++) check_val("grant_order", order[i], exp_order[i]);
    CpuReq = 1'b0; DbgReq = 1'b0;
    step();

    // one-cycle debug pulse, read of 0x7FF
    DbgReq = 1'b1; DbgWr = 1'b0; DbgAddr = 11'h7FF;
    step();
    DbgReq = 1'b0;
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      step();
      if (DbgAck) n = 1;
    end
    check_val("pulse_dbgack", n, 1);
    check_val("pulse_dbgrddata", DbgRdData, 16'h1234);
    step();

    // reset during ISSUE of a write
    CpuReq = 1'b1; CpuWr = 1'b1; CpuAddr = 11'h009; CpuWrData = 16'hA5A5;
    step();
    check_val("rst_pre_memwr", MemWr, 1'b1);
    Reset = 1'b1;
    #1;
    check_val("rst_memwr", MemWr, 1'b0);
    check_val("rst_busy", Busy, 1'b0);
    check_val("rst_cpuack", CpuAck, 1'b0);
    model_reset();
    CpuReq = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) step();

    // random back-to-back traffic
    for (int c = 0; c < 1500; c++) begin
      step();
      rand_port(e_cack, CpuReq, CpuWr, CpuAddr, CpuWrData);
      rand_port(e_dack, DbgReq, DbgWr, DbgAddr, DbgWrData);
    end
    CpuReq = 1'b0; DbgReq = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 16; i++) check_val("mem_image", mem[i], ref_mem[i]);
    check_val("mem_image_7ff", mem[11'h7FF], ref_mem[11'h7FF]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
